// File: rtl/cluster_config_pkg.sv
// Shared definitions for the cluster configuration feeder: header command
// encodings, FSM state set and the write-counter width.
package cluster_config_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE   = 2'b00,
        CMD_RESET   = 2'b01,
        CMD_END     = 2'b10,
        CMD_ILLEGAL = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_CNT,
        ST_LOAD,
        ST_SETUP,
        ST_STROBE,
        ST_DRAIN,
        ST_RST,
        ST_DONE
    } state_e;

    localparam int WRITE_COUNT_W = 16;

endpackage

// File: rtl/cluster_config_feeder_if.sv
// Byte-serial bitstream channel with a valid/ready handshake; the source is
// the master, the feeder is the slave.
interface cluster_config_feeder_if #(
    parameter int DATA_SIZE = 8
) ();

    logic [DATA_SIZE-1:0] IN_DATA;
    logic                 IN_VALID;
    logic                 IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);

endinterface

// File: rtl/cluster_config_feeder.sv
// Decodes framed configuration commands from a byte stream and turns each
// payload byte into one setup/strobe write on the cluster loader bus.
module cluster_config_feeder
    import cluster_config_pkg::*;
#(
    parameter int DATA_SIZE    = 8,
    parameter int ADDRESS_SIZE = 6,
    parameter int MAX_ADDR     = 63,
    parameter int RESET_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    cluster_config_feeder_if.slave   stream,
    output logic [DATA_SIZE-1:0]     DATA,
    output logic [ADDRESS_SIZE-1:0]  ADDRESS,
    output logic                     SELECT_LEVEL,
    output logic                     LOADER_RESET,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERROR,
    output logic [WRITE_COUNT_W-1:0] WRITE_COUNT
);

    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    // One spare address bit so that MAX_ADDR + 1 shows up as overflow.
    typedef logic [ADDRESS_SIZE:0] acnt_t;
    typedef logic [DATA_SIZE:0]    rem_t;
    typedef logic [RCW-1:0]        rcnt_t;

    localparam acnt_t MAX_A    = acnt_t'(MAX_ADDR);
    localparam rem_t  REM_FULL = rem_t'(1 << DATA_SIZE);
    localparam rcnt_t RC_LAST  = rcnt_t'(RESET_CYCLES - 1);

    state_e state, state_nxt;
    acnt_t  acnt;
    rem_t   rem;
    rcnt_t  rcnt;

    logic accept, overflow, rem_last;
    cmd_e hdr_cmd;

    assign accept   = stream.IN_VALID && stream.IN_READY;
    assign hdr_cmd  = cmd_e'(stream.IN_DATA[DATA_SIZE-1 -: 2]);
    assign overflow = acnt > MAX_A;
    assign rem_last = rem == rem_t'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_HDR;
        else       state <= state_nxt;
    end

    // NOTE: next state is defaulted first so no path through the case can
    // infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HDR: begin
                if (accept) begin
                    case (hdr_cmd)
                        CMD_WRITE: state_nxt = ST_CNT;
                        CMD_RESET: state_nxt = ST_RST;
                        CMD_END:   state_nxt = ST_DONE;
                        default:   state_nxt = ST_HDR;
                    endcase
                end
            end
            ST_CNT:    if (accept) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    if (!overflow)     state_nxt = ST_SETUP;
                    else if (rem_last) state_nxt = ST_HDR;
                    else               state_nxt = ST_DRAIN;
                end
            end
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = rem_last ? ST_HDR : ST_LOAD;
            ST_DRAIN:  if (accept && rem_last) state_nxt = ST_HDR;
            ST_RST:    if (rcnt == '0) state_nxt = ST_HDR;
            ST_DONE:   state_nxt = ST_DONE;
            default:   state_nxt = ST_HDR;
        endcase
    end

    assign stream.IN_READY = !RESET &&
                             (state inside {ST_HDR, ST_CNT, ST_LOAD, ST_DRAIN});
    assign SELECT_LEVEL    = state == ST_STROBE;
    assign LOADER_RESET    = state == ST_RST;
    assign DONE            = state == ST_DONE;
    assign BUSY            = !(state inside {ST_HDR, ST_DONE});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acnt        <= '0;
            rem         <= '0;
            rcnt        <= '0;
            DATA        <= '0;
            ADDRESS     <= '0;
            ERROR       <= 1'b0;
            WRITE_COUNT <= '0;
        end else begin
            case (state)
                ST_HDR: begin
                    if (accept) begin
                        case (hdr_cmd)
                            CMD_WRITE: acnt <= {1'b0, stream.IN_DATA[ADDRESS_SIZE-1:0]};
                            CMD_RESET: begin
                                rcnt    <= RC_LAST;
                                DATA    <= '0;
                                ADDRESS <= '0;
                            end
                            CMD_ILLEGAL: ERROR <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_CNT: begin
                    // A zero count byte stands for a full 2^DATA_SIZE burst.
                    if (accept)
                        rem <= (stream.IN_DATA == '0) ? REM_FULL : {1'b0, stream.IN_DATA};
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (overflow) begin
                            ERROR <= 1'b1;
                            rem   <= rem - 1'b1;
                        end else begin
                            DATA    <= stream.IN_DATA;
                            ADDRESS <= acnt[ADDRESS_SIZE-1:0];
                        end
                    end
                end
                ST_STROBE: begin
                    if (WRITE_COUNT != '1) WRITE_COUNT <= WRITE_COUNT + 1'b1;
                    acnt <= acnt + 1'b1;
                    rem  <= rem - 1'b1;
                end
                ST_DRAIN: if (accept) rem <= rem - 1'b1;
                ST_RST:   if (rcnt != '0) rcnt <= rcnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cluster_config_feeder.sv
// Randomized bench for cluster_config_feeder: a scoreboard derives expected
// loader writes from frame contents and checks each strobe as it happens.
module tb_cluster_config_feeder;
    import cluster_config_pkg::*;

    localparam int DATA_SIZE    = 8;
    localparam int ADDRESS_SIZE = 6;
    localparam int MAX_ADDR     = 63;
    localparam int RESET_CYCLES = 4;
    localparam int BOUND        = 2000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  DATA;
    logic [5:0]  ADDRESS;
    logic        SELECT_LEVEL, LOADER_RESET, BUSY, DONE, ERROR;
    logic [15:0] WRITE_COUNT;

    cluster_config_feeder_if #(.DATA_SIZE(DATA_SIZE)) stream ();

    cluster_config_feeder #(
        .DATA_SIZE(DATA_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE),
        .MAX_ADDR(MAX_ADDR), .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .CLK(CLK), .RESET(RESET), .stream(stream),
        .DATA(DATA), .ADDRESS(ADDRESS), .SELECT_LEVEL(SELECT_LEVEL),
        .LOADER_RESET(LOADER_RESET), .BUSY(BUSY), .DONE(DONE),
        .ERROR(ERROR), .WRITE_COUNT(WRITE_COUNT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        expect_q[$];
    int         strobe_cyc[$];
    int         acc_q[$];
    int         exp_wc = 0;
    logic       exp_err = 1'b0;
    logic [7:0] prev_data;
    logic [5:0] prev_addr;

    // Scoreboard: each strobe must match the next expected write and carry
    // the same DATA/ADDRESS that was already on the bus one cycle earlier.
    always @(negedge CLK) begin
        if (SELECT_LEVEL === 1'b1) begin
            vectors++;
            if (expect_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_strobe: got addr=%0d data=%h, required no strobe", ADDRESS, DATA);
            end else begin
                wr_t e;
                e = expect_q.pop_front();
                if (ADDRESS !== e.addr || DATA !== e.data || DATA !== prev_data || ADDRESS !== prev_addr) begin
                    miscompares++;
                    $display("FAIL strobe: got addr=%0d data=%h (prev addr=%0d data=%h), required addr=%0d data=%h held",
                             ADDRESS, DATA, prev_addr, prev_data, e.addr, e.data);
                end
            end
            strobe_cyc.push_back(cyc);
        end
        prev_data = DATA;
        prev_addr = ADDRESS;
    end

    task automatic send(input logic [7:0] b, input int gap_max, output int acc_cyc);
        int n = 0;
        stream.IN_VALID = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge CLK);
        stream.IN_DATA  = b;
        stream.IN_VALID = 1'b1;
        while (stream.IN_READY !== 1'b1 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        acc_cyc = cyc;
        @(negedge CLK);
        stream.IN_VALID = 1'b0;
        if (n >= BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted, required accept within %0d cycles", b, BOUND);
        end
    endtask

    // Reference: byte i of a burst lands at base+i unless that exceeds MAX_ADDR.
    task automatic run_burst(input int base, input int count, input logic [7:0] payload[$], input int gap_max);
        int a;
        for (int i = 0; i < count; i++) begin
            if (base + i <= MAX_ADDR) begin
                expect_q.push_back('{addr: 6'(base + i), data: payload[i]});
                if (exp_wc < 65535) exp_wc++;
            end else begin
                exp_err = 1'b1;
            end
        end
        send({2'b00, 6'(base)}, gap_max, a); acc_q.push_back(a);
        send(8'(count), gap_max, a);         acc_q.push_back(a);
        for (int i = 0; i < count; i++) begin
            send(payload[i], gap_max, a);
            acc_q.push_back(a);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < BOUND) begin
            @(negedge CLK);
            n++;
        end
        if (n >= BOUND) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_idle_timeout: BUSY still %b, required 0 within %0d cycles", name, BUSY, BOUND);
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        stream.IN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        expect_q.delete();
        strobe_cyc.delete();
        exp_wc  = 0;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        stream.IN_VALID = 1'b0;
        stream.IN_DATA  = '0;
        repeat (3) @(negedge CLK);
        vectors++;
        if ({stream.IN_READY, SELECT_LEVEL, LOADER_RESET, BUSY, DONE, ERROR} !== 6'b0 ||
            DATA !== 8'h00 || ADDRESS !== 6'd0 || WRITE_COUNT !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b sel=%b lrst=%b busy=%b done=%b err=%b data=%h addr=%0d wc=%0d, required all 0",
                     stream.IN_READY, SELECT_LEVEL, LOADER_RESET, BUSY, DONE, ERROR, DATA, ADDRESS, WRITE_COUNT);
        end
        RESET = 1'b0;
        @(negedge CLK);
        vectors++;
        if (stream.IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, required 1", stream.IN_READY);
        end
    endtask

    task automatic test_basic_burst();
        logic [7:0] p[$];
        p = '{8'hA1, 8'hB2, 8'hC3};
        acc_q.delete();
        strobe_cyc.delete();
        run_burst(5, 3, p, 0);
        wait_idle("basic");
        vectors++;
        if (strobe_cyc.size() != 3) begin
            miscompares++;
            $display("FAIL basic_strobes: got %0d strobes, required 3", strobe_cyc.size());
        end else begin
            vectors++;
            if (strobe_cyc[0] != acc_q[2] + 2 || strobe_cyc[1] - strobe_cyc[0] != 3 || strobe_cyc[2] - strobe_cyc[1] != 3) begin
                miscompares++;
                $display("FAIL basic_timing: strobes at %0d,%0d,%0d with first accept %0d, required accept+2 then spacing 3",
                         strobe_cyc[0], strobe_cyc[1], strobe_cyc[2], acc_q[2]);
            end
        end
        vectors++;
        if (expect_q.size() != 0 || WRITE_COUNT !== 16'd3 || ERROR !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_status: pending=%0d wc=%0d err=%b, required 0, 3, 0", expect_q.size(), WRITE_COUNT, ERROR);
        end
    endtask

    task automatic test_addr_overflow();
        logic [7:0] p[$];
        for (int i = 0; i < 4; i++) p.push_back(8'($urandom));
        strobe_cyc.delete();
        run_burst(62, 4, p, 0);
        wait_idle("overflow");
        vectors++;
        if (strobe_cyc.size() != 2 || expect_q.size() != 0 || ERROR !== 1'b1 || WRITE_COUNT !== 16'(exp_wc)) begin
            miscompares++;
            $display("FAIL overflow: strobes=%0d pending=%0d err=%b wc=%0d, required 2, 0, 1, %0d",
                     strobe_cyc.size(), expect_q.size(), ERROR, WRITE_COUNT, exp_wc);
        end
        p.delete();
        p.push_back(8'($urandom));
        run_burst(16, 1, p, 0);
        wait_idle("overflow_next");
        vectors++;
        if (expect_q.size() != 0 || WRITE_COUNT !== 16'(exp_wc)) begin
            miscompares++;
            $display("FAIL overflow_next_frame: pending=%0d wc=%0d, required 0, %0d", expect_q.size(), WRITE_COUNT, exp_wc);
        end
    endtask

    task automatic test_loader_reset();
        int a;
        send(8'h40, 0, a);
        // Now in cycle a+1: pulse expected over a+1 .. a+RESET_CYCLES.
        for (int i = 1; i <= RESET_CYCLES + 1; i++) begin
            logic exp_lr;
            exp_lr = (i <= RESET_CYCLES);
            vectors++;
            if (LOADER_RESET !== exp_lr || stream.IN_READY !== !exp_lr || BUSY !== exp_lr ||
                DATA !== 8'h00 || ADDRESS !== 6'd0 || SELECT_LEVEL !== 1'b0) begin
                miscompares++;
                $display("FAIL loader_reset_t%0d: lrst=%b ready=%b busy=%b data=%h addr=%0d sel=%b, required lrst=%b ready=%b busy=%b data=00 addr=0 sel=0",
                         i, LOADER_RESET, stream.IN_READY, BUSY, DATA, ADDRESS, SELECT_LEVEL, exp_lr, !exp_lr, exp_lr);
            end
            if (i <= RESET_CYCLES) @(negedge CLK);
        end
    endtask

    task automatic test_random_bursts();
        for (int k = 0; k < 12; k++) begin
            logic [7:0] p[$];
            int base, count;
            base  = $urandom_range(0, MAX_ADDR);
            count = $urandom_range(1, 6);
            for (int i = 0; i < count; i++) p.push_back(8'($urandom));
            run_burst(base, count, p, 2);
        end
        wait_idle("random");
        vectors++;
        if (expect_q.size() != 0 || WRITE_COUNT !== 16'(exp_wc) || ERROR !== exp_err) begin
            miscompares++;
            $display("FAIL random_bursts: pending=%0d wc=%0d err=%b, required 0, %0d, %b",
                     expect_q.size(), WRITE_COUNT, ERROR, exp_wc, exp_err);
        end
    endtask

    task automatic test_illegal_and_256();
        int a;
        logic [7:0] p[$];
        apply_reset();
        send(8'hC0, 0, a);
        exp_err = 1'b1;
        vectors++;
        if (ERROR !== 1'b1 || stream.IN_READY !== 1'b1 || BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_hdr: err=%b ready=%b busy=%b, required 1, 1, 0", ERROR, stream.IN_READY, BUSY);
        end
        for (int i = 0; i < 256; i++) p.push_back(8'($urandom));
        strobe_cyc.delete();
        run_burst(0, 256, p, 0);
        wait_idle("count256");
        vectors++;
        if (strobe_cyc.size() != 64 || expect_q.size() != 0 || WRITE_COUNT !== 16'd64 || ERROR !== 1'b1) begin
            miscompares++;
            $display("FAIL count256: strobes=%0d pending=%0d wc=%0d err=%b, required 64, 0, 64, 1",
                     strobe_cyc.size(), expect_q.size(), WRITE_COUNT, ERROR);
        end
    endtask

    task automatic test_reset_mid_burst();
        int a;
        logic [7:0] b;
        b = 8'($urandom_range(1, 255));
        strobe_cyc.delete();
        send(8'h05, 0, a);
        send(8'h02, 0, a);
        send(b, 0, a);
        // Now in the SETUP cycle of the first write.
        vectors++;
        if (BUSY !== 1'b1 || DATA !== b || ADDRESS !== 6'd5 || SELECT_LEVEL !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_setup: busy=%b data=%h addr=%0d sel=%b, required 1, %h, 5, 0", BUSY, DATA, ADDRESS, SELECT_LEVEL, b);
        end
        RESET = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({stream.IN_READY, SELECT_LEVEL, LOADER_RESET, BUSY, DONE, ERROR} !== 6'b0 ||
            DATA !== 8'h00 || ADDRESS !== 6'd0 || WRITE_COUNT !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: ready=%b sel=%b lrst=%b busy=%b done=%b err=%b data=%h addr=%0d wc=%0d, required all 0",
                     stream.IN_READY, SELECT_LEVEL, LOADER_RESET, BUSY, DONE, ERROR, DATA, ADDRESS, WRITE_COUNT);
        end
        RESET = 1'b0;
        expect_q.delete();
        exp_wc  = 0;
        exp_err = 1'b0;
        repeat (5) @(negedge CLK);
        vectors++;
        if (strobe_cyc.size() != 0 || stream.IN_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_after: strobes=%0d ready=%b, required 0, 1", strobe_cyc.size(), stream.IN_READY);
        end
    endtask

    task automatic test_end_and_stall();
        int a, base;
        logic [7:0] p[$];
        base = $urandom_range(0, 50);
        for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
        run_burst(base, 5, p, 4);
        send(8'h80, 3, a);
        vectors++;
        if (DONE !== 1'b1 || stream.IN_READY !== 1'b0 || BUSY !== 1'b0 || expect_q.size() != 0 || WRITE_COUNT !== 16'(exp_wc)) begin
            miscompares++;
            $display("FAIL end_frame: done=%b ready=%b busy=%b pending=%0d wc=%0d, required 1, 0, 0, 0, %0d",
                     DONE, stream.IN_READY, BUSY, expect_q.size(), WRITE_COUNT, exp_wc);
        end
        stream.IN_DATA  = 8'h05;
        stream.IN_VALID = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            vectors++;
            if (DONE !== 1'b1 || stream.IN_READY !== 1'b0 || SELECT_LEVEL !== 1'b0) begin
                miscompares++;
                $display("FAIL done_stall: done=%b ready=%b sel=%b, required 1, 0, 0", DONE, stream.IN_READY, SELECT_LEVEL);
            end
        end
        stream.IN_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stream.IN_VALID = 1'b0;
        stream.IN_DATA  = '0;
        test_reset();
        test_basic_burst();
        test_addr_overflow();
        test_loader_reset();
        test_random_bursts();
        test_illegal_and_256();
        test_reset_mid_burst();
        test_end_and_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
